mp_cache_tag_way_array: RTL and testbench
=========================================

# mp_cache_tag_way_array

Parametrised multi-way tag store for the set-associative caches: per set it holds WAYS tags, each with a valid and a dirty bit, and produces a per-way hit vector against a supplied compare tag. It keeps the single-RW-port timing of the existing OpenRAM macros (inputs registered on the clock edge, read data flows from the registered address), so cache controllers swap in without re-timing. It adds a per-way write mask, a resettable valid/dirty state, a one-cycle flush, and deselect that cancels pending writes.

## Interface
- TAG_WIDTH, 23, tag bits per way
- ADDR_WIDTH, 5, set index width; SETS = 1 << ADDR_WIDTH
- WAYS, 4, number of ways (>= 1)

- clk0  in  1  clock, all state updates on rising edge
- rst0  in  1  reset, asynchronous, active-high
- csb0  in  1  active-low chip select; request captured only when 0
- web0  in  1  active-low write enable, captured with request
- wmask0  in  WAYS  per-way write mask, captured with request
- addr0  in  ADDR_WIDTH  set index
- din0  in  TAG_WIDTH  tag written to every masked way
- vin0  in  1  valid bit written to masked ways
- din_dirty0  in  1  dirty bit written to masked ways
- cmp_tag0  in  TAG_WIDTH  tag compared against all ways of the set
- flush0  in  1  synchronous clear of all valid and dirty bits
- dout0  out  WAYS*TAG_WIDTH  way w at [w*TAG_WIDTH +: TAG_WIDTH]; 0 for invalid ways
- valid0  out  WAYS  valid bits of registered set
- dirty0  out  WAYS  dirty bits of registered set
- hit0  out  WAYS  valid0[w] & (tag[w] == registered cmp_tag)
- hit_any0  out  1  OR of hit0

## Operation
- Capture: at rising edge with csb0=0, register addr0, cmp_tag0, din0, vin0, din_dirty0, wmask0, and write-pending = !web0 & (wmask0 != 0).
- At a rising edge with csb0=1: addr/cmp_tag registers hold; write-pending cleared to 0.
- Write commit: at the edge following capture, if write-pending=1, each way w with wmask_reg[w]=1 at set addr_reg gets tag=din_reg, valid=vin_reg, dirty=din_dirty_reg. Unmasked ways unchanged.
- Commit uses pre-edge register values; a new request captured on the same edge does not redirect it.
- Read outputs are combinational from storage and addr_reg/cmp_tag_reg; no read enable.
- hit0 is not guaranteed one-hot; duplicate valid tags give multiple bits (controller bug, no arbitration here).
- flush0=1 at an edge: every valid and dirty bit in every set cleared. Beats a same-edge commit for valid/dirty; the tag field is still written.
- Tag storage is not reset; valid/dirty live in flops (SETS*WAYS*2 bits).
- Reset (rst0=1, asynchronous): all valid/dirty = 0; addr_reg, cmp_tag_reg, din_reg, wmask_reg = 0; write-pending = 0.
- Output reset values: valid0=0, dirty0=0, hit0=0, hit_any0=0, dout0=0.
- Reset asserted with a write pending: the write is dropped.

## Timing
- Read latency: request captured at edge N; dout0/valid0/dirty0/hit0 reflect that set and tag after edge N (clk-to-q plus comparator). They hold until the next capture or commit.
- Write: captured at edge N; storage updated at edge N+1. Between N and N+1, outputs show pre-write contents of that set.
- After edge N+1, outputs show written values if addr_reg is unchanged.
- Back-to-back write then read of the same set (edges N, N+1): the read at N+1 sees the new data.
- Back-to-back writes (edges N, N+1): commits occur at N+1 and N+2.
- Flush: takes effect at the sampling edge. Outputs show all-invalid from that edge.
- Reset release: first capture can occur on the first rising edge with rst0=0.

## Test plan
- Reset, then read set 0 with cmp_tag0=0 -> valid0=0, hit0=0, hit_any0=0, dout0=0.
- Write set 5 with wmask0=4'b0100, din0=23'h1ABCDE, vin0=1, din_dirty0=1, then read set 5 with cmp_tag0=23'h1ABCDE -> valid0=4'b0100, dirty0=4'b0100, hit0=4'b0100, dout0 way2=23'h1ABCDE.
- Write set 3, way0 tag 7; next cycle deselect (csb0=1) -> commit occurs once. Write on set 3 with csb0 held low at edge N then csb0=1 -> no further commit; verify a later write to set 3 way1 leaves way0 unchanged.
- Fill sets 0..31, all ways valid; assert flush0 one cycle -> every set reads valid0=0, dirty0=0, hit0=0; tags not checked.
- Flush coincident with a commit to set 9 way1 -> valid0 for set 9 = 0 after the edge.
- rst0 pulsed mid-cycle between capture of a write (set 12) and its commit edge -> after reset, set 12 valid0=0 and no commit occurs.
- Invalid way with a matching tag (write vin0=0, tag 23'h55) compared with 23'h55 -> hit0 bit 0, dout0 field 0.

Source files
------------

// File: rtl/mp_cache_tag_way_array_if.sv
// Request/response bundle of the multi-way tag store.
// Controller drives the request side, the array returns per-way state.
interface mp_cache_tag_way_array_if #(
  parameter int TAG_WIDTH  = 23,
  parameter int ADDR_WIDTH = 5,
  parameter int WAYS       = 4
);
  logic                      csb0;
  logic                      web0;
  logic [WAYS-1:0]           wmask0;
  logic [ADDR_WIDTH-1:0]     addr0;
  logic [TAG_WIDTH-1:0]      din0;
  logic                      vin0;
  logic                      din_dirty0;
  logic [TAG_WIDTH-1:0]      cmp_tag0;
  logic                      flush0;
  logic [WAYS*TAG_WIDTH-1:0] dout0;
  logic [WAYS-1:0]           valid0;
  logic [WAYS-1:0]           dirty0;
  logic [WAYS-1:0]           hit0;
  logic                      hit_any0;

  modport master (
    output csb0, web0, wmask0, addr0, din0,
    output vin0, din_dirty0, cmp_tag0, flush0,
    input  dout0, valid0, dirty0, hit0, hit_any0
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0,
    input  vin0, din_dirty0, cmp_tag0, flush0,
    output dout0, valid0, dirty0, hit0, hit_any0
  );
endinterface

// File: rtl/mp_cache_tag_way_array.sv
// Set-associative tag store: single RW port, registered request,
// per-way write mask, flush and combinational hit vector.
module mp_cache_tag_way_array #(
  parameter int TAG_WIDTH  = 23,
  parameter int ADDR_WIDTH = 5,
  parameter int WAYS       = 4
) (
  input logic clk0,
  input logic rst0,
  mp_cache_tag_way_array_if.slave bus
);
  localparam int SETS = 1 << ADDR_WIDTH;

  logic [TAG_WIDTH-1:0]  tag_mem [SETS][WAYS];
  logic [WAYS-1:0]       vld_mem [SETS];
  logic [WAYS-1:0]       drt_mem [SETS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TAG_WIDTH-1:0]  cmp_q;
  logic [TAG_WIDTH-1:0]  din_q;
  logic                  vin_q;
  logic                  drt_q;
  logic [WAYS-1:0]       wmask_q;
  logic                  wr_pend;

  logic [WAYS*TAG_WIDTH-1:0] dout;
  logic [WAYS-1:0]           hit;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      addr_q  <= '0;
      cmp_q   <= '0;
      din_q   <= '0;
      vin_q   <= 1'b0;
      drt_q   <= 1'b0;
      wmask_q <= '0;
      wr_pend <= 1'b0;
    end else if (!bus.csb0) begin
      addr_q  <= bus.addr0;
      cmp_q   <= bus.cmp_tag0;
      din_q   <= bus.din0;
      vin_q   <= bus.vin0;
      drt_q   <= bus.din_dirty0;
      wmask_q <= bus.wmask0;
      wr_pend <= !bus.web0 && (bus.wmask0 != '0);
    end else begin
      wr_pend <= 1'b0;
    end
  end

  // Flush wins over a same-edge commit for the state bits only.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int s = 0; s < SETS; s++) begin
        vld_mem[s] <= '0;
        drt_mem[s] <= '0;
      end
    end else if (bus.flush0) begin
      for (int s = 0; s < SETS; s++) begin
        vld_mem[s] <= '0;
        drt_mem[s] <= '0;
      end
    end else if (wr_pend) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wmask_q[w]) begin
          vld_mem[addr_q][w] <= vin_q;
          drt_mem[addr_q][w] <= drt_q;
        end
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_pend) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wmask_q[w]) tag_mem[addr_q][w] <= din_q;
      end
    end
  end

  // Unwritten tags are never exposed: invalid ways read as zero.
  always_comb begin
    dout = '0;
    hit  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_mem[addr_q][w]) begin
        dout[w*TAG_WIDTH +: TAG_WIDTH] = tag_mem[addr_q][w];
        hit[w] = (tag_mem[addr_q][w] == cmp_q);
      end
    end
  end

  assign bus.dout0    = dout;
  assign bus.valid0   = vld_mem[addr_q];
  assign bus.dirty0   = drt_mem[addr_q];
  assign bus.hit0     = hit;
  assign bus.hit_any0 = |hit;
endmodule

// File: tb/tb_mp_cache_tag_way_array.sv
// Bench for mp_cache_tag_way_array: directed table, corner sequences
// and random traffic against a transaction-level model.
module tb_mp_cache_tag_way_array;
  localparam int TW = 23;
  localparam int AW = 5;
  localparam int W  = 4;
  localparam int NS = 1 << AW;
  localparam int DW = W * TW;

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  always #5 clk0 = ~clk0;

  mp_cache_tag_way_array_if #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .WAYS(W)) ifc ();

  mp_cache_tag_way_array #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .WAYS(W)) dut (
    .clk0(clk0),
    .rst0(rst0),
    .bus (ifc.slave)
  );

  typedef struct {
    logic          csb, web;
    logic [W-1:0]  mask;
    logic [AW-1:0] addr;
    logic [TW-1:0] din;
    logic          vin, dty;
    logic [TW-1:0] cmp;
    logic          flush;
    logic [W-1:0]  e_val, e_dty, e_hit;
    logic          e_any;
    logic [DW-1:0] e_dout;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  m;
    logic [TW-1:0] t;
    logic          v, d;
  } wr_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [TW-1:0] m_tag [NS][W];
  logic [W-1:0]  m_val [NS];
  logic [W-1:0]  m_dty [NS];
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_cmp;
  wr_t           pq[$];

  vec_t tbl[10];

  function automatic logic [DW-1:0] fld(int w, logic [TW-1:0] t);
    logic [DW-1:0] x;
    x = '0;
    x[TW-1:0] = t;
    return x << (w * TW);
  endfunction

  function automatic vec_t mk(
    logic csb, logic web, logic [W-1:0] mask, logic [AW-1:0] addr,
    logic [TW-1:0] din, logic vin, logic dty, logic [TW-1:0] cmp,
    logic [W-1:0] ev, logic [W-1:0] ed, logic [W-1:0] eh,
    logic ea, logic [DW-1:0] eo);
    vec_t r;
    r.csb = csb; r.web = web; r.mask = mask; r.addr = addr;
    r.din = din; r.vin = vin; r.dty = dty; r.cmp = cmp;
    r.flush = 1'b0;
    r.e_val = ev; r.e_dty = ed; r.e_hit = eh; r.e_any = ea;
    r.e_dout = eo;
    return r;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic csb, logic web, logic [W-1:0] mask,
                       logic [AW-1:0] addr, logic [TW-1:0] din,
                       logic vin, logic dty, logic [TW-1:0] cmp,
                       logic flush);
    ifc.csb0 = csb; ifc.web0 = web; ifc.wmask0 = mask;
    ifc.addr0 = addr; ifc.din0 = din; ifc.vin0 = vin;
    ifc.din_dirty0 = dty; ifc.cmp_tag0 = cmp; ifc.flush0 = flush;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_val[s] = '0;
      m_dty[s] = '0;
    end
    m_addr = '0;
    m_cmp  = '0;
    pq.delete();
  endtask

  // One clock: the write queued last cycle lands, flush wipes state,
  // then the new request is accepted.
  task automatic tick();
    wr_t p;
    @(posedge clk0);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      for (int w = 0; w < W; w++) begin
        if (p.m[w]) begin
          m_tag[p.a][w] = p.t;
          m_val[p.a][w] = p.v;
          m_dty[p.a][w] = p.d;
        end
      end
    end
    if (ifc.flush0) begin
      for (int s = 0; s < NS; s++) begin
        m_val[s] = '0;
        m_dty[s] = '0;
      end
    end
    if (!ifc.csb0) begin
      m_addr = ifc.addr0;
      m_cmp  = ifc.cmp_tag0;
      if (!ifc.web0 && ifc.wmask0 != '0) begin
        p.a = ifc.addr0; p.m = ifc.wmask0; p.t = ifc.din0;
        p.v = ifc.vin0;  p.d = ifc.din_dirty0;
        pq.push_back(p);
      end
    end
    #1;
  endtask

  task automatic chk_model(string nm);
    logic [W-1:0]  ev, eh;
    logic [DW-1:0] eo;
    ev = m_val[m_addr];
    eh = '0;
    eo = '0;
    for (int w = 0; w < W; w++) begin
      if (ev[w]) begin
        eo |= fld(w, m_tag[m_addr][w]);
        eh[w] = (m_tag[m_addr][w] == m_cmp);
      end
    end
    chk({nm, ".valid"}, DW'(ifc.valid0), DW'(ev));
    chk({nm, ".dirty"}, DW'(ifc.dirty0), DW'(m_dty[m_addr]));
    chk({nm, ".hit"}, DW'(ifc.hit0), DW'(eh));
    chk({nm, ".hit_any"}, DW'(ifc.hit_any0), DW'(|eh));
    chk({nm, ".dout"}, ifc.dout0, eo);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, ".valid"}, DW'(ifc.valid0), '0);
    chk({nm, ".dirty"}, DW'(ifc.dirty0), '0);
    chk({nm, ".hit"}, DW'(ifc.hit0), '0);
    chk({nm, ".hit_any"}, DW'(ifc.hit_any0), '0);
  endtask

  logic [TW-1:0] pool [4];

  initial begin
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < W; w++) m_tag[s][w] = '0;
    model_reset();
    drive(1, 1, '0, '0, '0, 0, 0, '0, 0);

    tbl[0] = mk(0, 1, 4'b0000, 5'd0, 23'h0, 0, 0, 23'h0,
                4'b0000, 4'b0000, 4'b0000, 0, '0);
    tbl[1] = mk(0, 0, 4'b0100, 5'd5, 23'h1ABCDE, 1, 1, 23'h1ABCDE,
                4'b0000, 4'b0000, 4'b0000, 0, '0);
    tbl[2] = mk(0, 1, 4'b0000, 5'd5, 23'h0, 0, 0, 23'h1ABCDE,
                4'b0100, 4'b0100, 4'b0100, 1, fld(2, 23'h1ABCDE));
    tbl[3] = mk(0, 0, 4'b0001, 5'd3, 23'h7, 1, 0, 23'h7,
                4'b0000, 4'b0000, 4'b0000, 0, '0);
    tbl[4] = mk(1, 0, 4'b1111, 5'd0, 23'h3, 1, 1, 23'h3,
                4'b0001, 4'b0000, 4'b0001, 1, fld(0, 23'h7));
    tbl[5] = mk(1, 0, 4'b1111, 5'd3, 23'h3, 1, 1, 23'h3,
                4'b0001, 4'b0000, 4'b0001, 1, fld(0, 23'h7));
    tbl[6] = mk(0, 0, 4'b0010, 5'd3, 23'h9, 1, 1, 23'h7,
                4'b0001, 4'b0000, 4'b0001, 1, fld(0, 23'h7));
    tbl[7] = mk(0, 1, 4'b0000, 5'd3, 23'h0, 0, 0, 23'h9,
                4'b0011, 4'b0010, 4'b0010, 1,
                fld(0, 23'h7) | fld(1, 23'h9));
    tbl[8] = mk(0, 0, 4'b0001, 5'd7, 23'h55, 0, 0, 23'h55,
                4'b0000, 4'b0000, 4'b0000, 0, '0);
    tbl[9] = mk(0, 1, 4'b0000, 5'd7, 23'h0, 0, 0, 23'h55,
                4'b0000, 4'b0000, 4'b0000, 0, '0);

    #12 rst0 = 1'b0;
    #1;
    chk_zero("reset");
    chk("reset.dout", ifc.dout0, '0);

    foreach (tbl[i]) begin
      drive(tbl[i].csb, tbl[i].web, tbl[i].mask, tbl[i].addr,
            tbl[i].din, tbl[i].vin, tbl[i].dty, tbl[i].cmp,
            tbl[i].flush);
      tick();
      chk($sformatf("tbl%0d.valid", i), DW'(ifc.valid0), DW'(tbl[i].e_val));
      chk($sformatf("tbl%0d.dirty", i), DW'(ifc.dirty0), DW'(tbl[i].e_dty));
      chk($sformatf("tbl%0d.hit", i), DW'(ifc.hit0), DW'(tbl[i].e_hit));
      chk($sformatf("tbl%0d.any", i), DW'(ifc.hit_any0), DW'(tbl[i].e_any));
      chk($sformatf("tbl%0d.dout", i), ifc.dout0, tbl[i].e_dout);
    end

    for (int s = 0; s < NS; s++) begin
      drive(0, 0, 4'hF, AW'(s), TW'(32'h100 + s), 1, 1, TW'(32'h100 + s), 0);
      tick();
      chk_model($sformatf("fill%0d", s));
    end
    drive(1, 1, '0, '0, '0, 0, 0, '0, 0);
    tick();
    chk("fill_last.valid", DW'(ifc.valid0), DW'(4'hF));
    chk("fill_last.hit", DW'(ifc.hit0), DW'(4'b1111));
    drive(1, 1, '0, '0, '0, 0, 0, '0, 1);
    tick();
    chk_zero("flush_now");
    for (int s = 0; s < NS; s++) begin
      drive(0, 1, '0, AW'(s), '0, 0, 0, TW'(32'h100 + s), 0);
      tick();
      chk_zero($sformatf("flushed%0d", s));
    end

    drive(0, 0, 4'b0010, 5'd9, 23'h999, 1, 1, 23'h999, 0);
    tick();
    drive(0, 1, '0, 5'd9, '0, 0, 0, 23'h999, 1);
    tick();
    chk_zero("flush_commit");
    drive(0, 1, '0, 5'd9, '0, 0, 0, 23'h999, 0);
    tick();
    chk_zero("flush_commit_after");

    drive(0, 0, 4'b0001, 5'd12, 23'h12, 1, 1, 23'h12, 0);
    tick();
    #2 rst0 = 1'b1;
    model_reset();
    #2 rst0 = 1'b0;
    #1;
    chk_zero("midreset");
    chk("midreset.dout", ifc.dout0, '0);
    drive(0, 1, '0, 5'd12, '0, 0, 0, 23'h12, 0);
    tick();
    chk_zero("midreset_set12");
    drive(1, 1, '0, '0, '0, 0, 0, '0, 0);
    tick();
    chk_zero("midreset_set12_later");

    pool[0] = 23'h0; pool[1] = 23'h55; pool[2] = 23'h7FFFFF; pool[3] = 23'h1ABCDE;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            W'($urandom), AW'($urandom_range(0, 7)),
            pool[$urandom_range(0, 3)], $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)],
            $urandom_range(0, 39) == 0);
      tick();
      chk_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
